instr_dispatch: RTL and testbench

Instruction front-end for the matrix coprocessor. Accepts 32-bit instruction words from the HPS-side bridge over a valid/ready handshake and buffers them in a small FIFO. Issues each legal instruction to the control unit as a one-cycle `start` pulse with a stable opcode and operand fields, then waits for the control unit to finish before issuing the next. Tracks completion count, sticky overflow and illegal-opcode flags for HPS readback.

---
 rtl/instr_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_instr_dispatch.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_dispatch
//
// Instruction front-end for the matrix coprocessor. Instruction words arrive
// from the HPS bridge over a valid/ready handshake and are buffered in a small
// FIFO. Each legal instruction is issued to the control unit as a one-cycle
// start pulse with stable opcode/size/scalar fields. The block then waits for
// the control unit to go busy and come back idle before issuing the next one.
// Completion count and sticky overflow / illegal-opcode flags are kept for HPS
// readback.
//
// Optional feature macro: DISPATCH_WDT_EN
//   When defined, a watchdog counts cycles spent in ACK and WAIT (restarting
//   on entry to each). Reaching WDT_CYCLES abandons the op, returns to IDLE
//   and raises the sticky err_timeout output. When undefined there is no
//   counter and no err_timeout port.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 2)
//   WDT_CYCLES  watchdog limit in cycles (only with DISPATCH_WDT_EN)
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   instr_data   instruction word: [2:0] opcode, [4:3] size, [12:5] scalar
//   instr_valid  instr_data valid
//   instr_ready  FIFO can accept (not full)
//   cu_ready     control unit idle/finished (level)
//   cu_overflow  control unit overflow, sampled at completion
//   clr_flags    clears sticky flags (a same-cycle set wins)
//   start        one-cycle issue pulse
//   op_code      issued opcode
//   mat_size     matrix size code (0=2x2 .. 3=5x5)
//   scalar       signed scalar operand
//   busy         FSM not idle or FIFO non-empty
//   fifo_count   entries held
//   err_illegal  sticky: an opcode-7 word was dropped
//   ovf_sticky   sticky: a completed op reported overflow
//   done_count   completed ops, wraps at 16 bits
//   err_timeout  sticky watchdog flag (DISPATCH_WDT_EN only)
// -----------------------------------------------------------------------------
module instr_dispatch #(
  parameter int DEPTH      = 4,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_data,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   cu_ready,
  input  logic                   cu_overflow,
  input  logic                   clr_flags,
  output logic                   start,
  output logic [2:0]             op_code,
  output logic [1:0]             mat_size,
  output logic [7:0]             scalar,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_illegal,
  output logic                   ovf_sticky,
  output logic [15:0]            done_count
`ifdef DISPATCH_WDT_EN
  ,
  output logic                   err_timeout
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 13;               // only bits [12:0] carry meaning
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] wr_en;
  logic [EW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  // Full is taken from the registered count, so a push never bypasses a
  // same-cycle pop when the FIFO is full.
  assign push       = instr_valid && !fifo_full;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Storage needs no reset: entries are only read while count_reg says valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= instr_data[EW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so IDLE can pop and load the operand
  // registers on the very next edge after a word lands in an empty FIFO.
  assign head = mem_reg[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_WAIT
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   load;
  logic   set_illegal;
  logic   complete;
  logic   wdt_clear;

`ifdef DISPATCH_WDT_EN
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;
  logic [WW-1:0] wdt_reg;
  logic          wdt_hit;
  logic          timeout;
  logic          err_timeout_reg;

  assign wdt_hit = (wdt_reg == WW'(WDT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    load        = 1'b0;
    set_illegal = 1'b0;
    complete    = 1'b0;
    wdt_clear   = 1'b0;
`ifdef DISPATCH_WDT_EN
    timeout     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // An illegal word is consumed in place; IDLE retries next cycle.
          if (head[2:0] == OP_ILLEGAL) begin
            set_illegal = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_ACK;
        wdt_clear  = 1'b1;
      end
      ST_ACK: begin
        // The control unit must first show it has taken the op (ready low).
        if (!cu_ready) begin
          state_next = ST_WAIT;
          wdt_clear  = 1'b1;
        end
`ifdef DISPATCH_WDT_EN
        else if (wdt_hit) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
      end
      ST_WAIT: begin
        if (cu_ready) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
`ifdef DISPATCH_WDT_EN
        else if (wdt_hit) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand registers, counters and sticky flags
  // ---------------------------------------------------------------------------
  logic [2:0]  op_code_reg;
  logic [1:0]  mat_size_reg;
  logic [7:0]  scalar_reg;
  logic [15:0] done_count_reg;
  logic        err_illegal_reg;
  logic        ovf_sticky_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_code_reg  <= '0;
      mat_size_reg <= '0;
      scalar_reg   <= '0;
    end else if (load) begin
      op_code_reg  <= head[2:0];
      mat_size_reg <= head[4:3];
      scalar_reg   <= head[12:5];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_count_reg  <= '0;
      err_illegal_reg <= 1'b0;
      ovf_sticky_reg  <= 1'b0;
    end else begin
      if (complete) begin
        done_count_reg <= done_count_reg + 16'd1;
      end
      // Set terms are OR-ed after the clear so a same-cycle set survives.
      err_illegal_reg <= set_illegal | (err_illegal_reg & ~clr_flags);
      ovf_sticky_reg  <= (complete & cu_overflow) | (ovf_sticky_reg & ~clr_flags);
    end
  end

`ifdef DISPATCH_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_reg         <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (wdt_clear) begin
        wdt_reg <= '0;
      end else if (state_reg == ST_ACK || state_reg == ST_WAIT) begin
        wdt_reg <= wdt_reg + 1'b1;
      end
      err_timeout_reg <= timeout | (err_timeout_reg & ~clr_flags);
    end
  end

  assign err_timeout = err_timeout_reg;

  logic unused_bits;
  assign unused_bits = ^instr_data[31:EW];
`else
  logic        unused_bits;
  logic [31:0] unused_wdt_cfg;
  assign unused_bits    = ^{instr_data[31:EW], wdt_clear};
  assign unused_wdt_cfg = WDT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_ready = !fifo_full;
  assign start       = (state_reg == ST_ISSUE);
  assign op_code     = op_code_reg;
  assign mat_size    = mat_size_reg;
  assign scalar      = scalar_reg;
  assign busy        = (state_reg != ST_IDLE) || !fifo_empty;
  assign fifo_count  = count_reg;
  assign err_illegal = err_illegal_reg;
  assign ovf_sticky  = ovf_sticky_reg;
  assign done_count  = done_count_reg;

endmodule

// File: tb/tb_instr_dispatch.sv
`timescale 1ns/1ps
// Self-checking bench for instr_dispatch. A queue-based reference model tracks
// which words should be issued (in order), how many completions the emulated
// control unit produced, and the sticky flag state.
module tb_instr_dispatch;

  localparam int DEPTH = 4;
`ifdef DISPATCH_WDT_EN
  localparam int WDT = 16;
`else
  localparam int WDT = 65535;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        instr_ready;
  logic        cu_ready;
  logic        cu_overflow;
  logic        clr_flags;
  logic        start;
  logic [2:0]  op_code;
  logic [1:0]  mat_size;
  logic [7:0]  scalar;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        err_illegal;
  logic        ovf_sticky;
  logic [15:0] done_count;
`ifdef DISPATCH_WDT_EN
  logic        err_timeout;
`endif

  instr_dispatch #(.DEPTH(DEPTH), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .cu_ready(cu_ready), .cu_overflow(cu_overflow),
    .clr_flags(clr_flags), .start(start), .op_code(op_code), .mat_size(mat_size),
    .scalar(scalar), .busy(busy), .fifo_count(fifo_count),
    .err_illegal(err_illegal), .ovf_sticky(ovf_sticky), .done_count(done_count)
`ifdef DISPATCH_WDT_EN
    , .err_timeout(err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_start = 0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  logic [31:0] send_q[$];
  int          exp_done;
  bit          exp_ovf;
  bit          exp_ill;

  // Issue monitor: one line per issued instruction.
  always @(negedge clk) begin
    if (!rst && start) begin
      got_q.push_back({op_code, mat_size, scalar});
      n_start++;
      $display("issue %0d: op=%0d size=%0d scalar=0x%02h at %0t",
               n_start, op_code, mat_size, scalar, $time);
    end
  end

  function automatic logic [12:0] fields(input logic [31:0] w);
    return {w[2:0], w[4:3], w[12:5]};
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_ill);
    logic [31:0] w;
    w = $urandom;
    if (!allow_ill && w[2:0] == 3'd7) w[2:0] = 3'($urandom_range(6, 0));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_data = '0; clr_flags = 1'b0;
    cu_ready = 1'b1; cu_overflow = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got_q.delete(); exp_q.delete(); send_q.delete();
    exp_done = 0; exp_ovf = 1'b0; exp_ill = 1'b0;
  endtask

  // Drives pushes from send_q and emulates the control unit: after each start
  // it drops cu_ready for 2..5 cycles, then raises it (the completion edge).
  // ovf_mode: 0 random, 1 force overflow, 2 force none.
  task automatic run_traffic(input int ovf_mode, input bit clr_at_done,
                             input bit pending_in, input int budget);
    int lo;
    int i;
    bit pending;
    bit acc;
    bit done_now;
    logic [31:0] w;
    lo = 0;
    pending = pending_in;
    for (i = 0; i < budget; i++) begin
      if (!pending && !busy && send_q.size() == 0) break;
      if (send_q.size() > 0 && $urandom_range(3, 0) != 0) begin
        instr_valid = 1'b1; instr_data = send_q[0];
      end else begin
        instr_valid = 1'b0; instr_data = $urandom;
      end
      acc = instr_valid && instr_ready;
      if (start) begin lo = $urandom_range(5, 2); pending = 1'b1; end
      cu_ready = (lo == 0);
      cu_overflow = (ovf_mode == 1) ? 1'b1 : (ovf_mode == 2) ? 1'b0 : 1'($urandom_range(1, 0));
      done_now = pending && (lo == 0);
      clr_flags = done_now && clr_at_done;
      tick();
      if (lo > 0) lo--;
      if (clr_flags) begin exp_ovf = 1'b0; exp_ill = 1'b0; end
      if (done_now) begin
        pending = 1'b0; exp_done++;
        if (cu_overflow) exp_ovf = 1'b1;
      end
      if (acc) begin
        w = send_q.pop_front();
        if (w[2:0] == 3'd7) exp_ill = 1'b1;
        else exp_q.push_back(fields(w));
      end
    end
    instr_valid = 1'b0; clr_flags = 1'b0; cu_ready = 1'b1;
    n_cmp++;
    if (i >= budget) begin
      n_err++; $display("FAIL traffic_budget: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset();
    logic [36:0] got;
    apply_reset();
    got = {instr_ready, start, op_code, mat_size, scalar, busy, fifo_count,
           err_illegal, ovf_sticky, done_count};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL reset_values: got %h required %h", got, 37'h1_0000_0000 << 4);
    end
  endtask

  task automatic test_single();
    logic [12:0] g;
    apply_reset();
    instr_data = 32'h0000_0021; instr_valid = 1'b1;
    tick();                       // accept edge k
    instr_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd1 || start !== 1'b0) begin
      n_err++; $display("FAIL single_accept: count=%0d start=%0d required 1/0", fifo_count, start);
    end
    tick();                       // pop edge k+1
    n_cmp++;
    if ({start, op_code, mat_size, scalar, fifo_count} !== {1'b1, 3'd1, 2'd0, 8'h01, 3'd0}) begin
      n_err++; $display("FAIL single_issue: start=%0d op=%0d size=%0d scalar=%h count=%0d required 1/1/0/01/0",
                        start, op_code, mat_size, scalar, fifo_count);
    end
    tick();
    n_cmp++;
    if (start !== 1'b0 || op_code !== 3'd1) begin
      n_err++; $display("FAIL single_pulse_len: start=%0d op=%0d required 0/1", start, op_code);
    end
    cu_ready = 1'b0;
    repeat (5) tick();
    cu_ready = 1'b1;
    tick();
    n_cmp++;
    if (done_count !== 16'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_done: done=%0d busy=%0d required 1/0", done_count, busy);
    end
    g = (got_q.size() > 0) ? got_q.pop_front() : 13'h1fff;
    n_cmp++;
    if (g !== fields(32'h21) || got_q.size() != 0) begin
      n_err++; $display("FAIL single_fields: got %h required %h", g, fields(32'h21));
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] w[DEPTH+2];
    logic [12:0] g;
    int k;
    apply_reset();
    foreach (w[i]) w[i] = rand_word(1'b0);
    instr_data = w[0]; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    exp_q.push_back(fields(w[0]));
    for (k = 0; k < 8 && !start; k++) tick();
    n_cmp++;
    if (start !== 1'b1) begin
      n_err++; $display("FAIL fill_first_start: start=%0d required 1", start);
    end
    cu_ready = 1'b0;
    tick(); tick();               // into ACK, then WAIT; held there
    for (int i = 1; i <= DEPTH; i++) begin
      instr_data = w[i]; instr_valid = 1'b1;
      n_cmp++;
      if (instr_ready !== 1'b1) begin
        n_err++; $display("FAIL fill_ready_%0d: ready=%0d required 1", i, instr_ready);
      end
      tick();
      exp_q.push_back(fields(w[i]));
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'(DEPTH) || instr_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_full: count=%0d ready=%0d required %0d/0", fifo_count, instr_ready, DEPTH);
    end
    instr_data = w[DEPTH+1]; instr_valid = 1'b1;
    tick(); tick();
    instr_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'(DEPTH)) begin
      n_err++; $display("FAIL fill_no_write: count=%0d required %0d", fifo_count, DEPTH);
    end
    run_traffic(0, 1'b0, 1'b1, 400);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fill_issue_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== exp_q[0]) begin
        n_err++; $display("FAIL fill_order: got %h required %h", g, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (done_count !== 16'(exp_done) || ovf_sticky !== exp_ovf || exp_done != DEPTH + 1) begin
      n_err++; $display("FAIL fill_done: done=%0d ovf=%0d required %0d/%0d", done_count, ovf_sticky, DEPTH + 1, exp_ovf);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] wi;
    logic [31:0] wl;
    logic [12:0] g;
    apply_reset();
    wi = $urandom; wi[2:0] = 3'd7;
    wl = $urandom; wl[2:0] = 3'd2;
    instr_data = wi; instr_valid = 1'b1;
    tick();                       // accept illegal
    instr_data = wl;
    tick();                       // accept legal, drop illegal
    instr_valid = 1'b0;
    n_cmp++;
    if (start !== 1'b0 || err_illegal !== 1'b1 || fifo_count !== 3'd1) begin
      n_err++; $display("FAIL illegal_drop: start=%0d err=%0d count=%0d required 0/1/1", start, err_illegal, fifo_count);
    end
    tick();
    n_cmp++;
    if (start !== 1'b1 || op_code !== 3'd2) begin
      n_err++; $display("FAIL illegal_next_issue: start=%0d op=%0d required 1/2", start, op_code);
    end
    exp_ill = 1'b1;
    exp_q.push_back(fields(wl));
    run_traffic(0, 1'b0, 1'b0, 200);
    g = (got_q.size() > 0) ? got_q.pop_front() : 13'h1fff;
    n_cmp++;
    if (g !== exp_q[0] || got_q.size() != 0 || done_count !== 16'd1 || err_illegal !== exp_ill) begin
      n_err++; $display("FAIL illegal_single_issue: fields=%h done=%0d err=%0d required %h/1/1", g, done_count, err_illegal, exp_q[0]);
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    n_cmp++;
    if (err_illegal !== 1'b0) begin
      n_err++; $display("FAIL illegal_clear: err=%0d required 0", err_illegal);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_q.push_back(rand_word(1'b0));
    run_traffic(1, 1'b0, 1'b0, 200);
    n_cmp++;
    if (ovf_sticky !== 1'b1 || done_count !== 16'd1) begin
      n_err++; $display("FAIL ovf_set: ovf=%0d done=%0d required 1/1", ovf_sticky, done_count);
    end
    send_q.push_back(rand_word(1'b0));
    run_traffic(2, 1'b0, 1'b0, 200);
    n_cmp++;
    if (ovf_sticky !== exp_ovf || exp_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky_hold: ovf=%0d required 1", ovf_sticky);
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    exp_ovf = 1'b0;
    n_cmp++;
    if (ovf_sticky !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: ovf=%0d required 0", ovf_sticky);
    end
    send_q.push_back(rand_word(1'b0));
    run_traffic(1, 1'b1, 1'b0, 200);
    n_cmp++;
    if (ovf_sticky !== 1'b1 || done_count !== 16'(exp_done) || got_q.size() != 3) begin
      n_err++; $display("FAIL ovf_set_beats_clear: ovf=%0d done=%0d issues=%0d required 1/%0d/3",
                        ovf_sticky, done_count, got_q.size(), exp_done);
    end
  endtask

  task automatic test_random_traffic();
    logic [12:0] g;
    apply_reset();
    for (int i = 0; i < 40; i++) send_q.push_back(rand_word(1'b1));
    run_traffic(0, 1'b0, 1'b0, 5000);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_issue_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      n_cmp++;
      if (g !== exp_q[0]) begin
        n_err++; $display("FAIL rand_order: got %h required %h", g, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (done_count !== 16'(exp_done) || ovf_sticky !== exp_ovf || err_illegal !== exp_ill || busy !== 1'b0) begin
      n_err++; $display("FAIL rand_final: done=%0d ovf=%0d ill=%0d busy=%0d required %0d/%0d/%0d/0",
                        done_count, ovf_sticky, err_illegal, busy, exp_done, exp_ovf, exp_ill);
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] got;
    int s;
    int k;
    apply_reset();
    instr_data = rand_word(1'b0); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (k = 0; k < 8 && !start; k++) tick();
    cu_ready = 1'b0;
    tick(); tick();               // in WAIT
    for (int i = 0; i < 2; i++) begin
      instr_data = rand_word(1'b0); instr_valid = 1'b1; tick();
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_setup: count=%0d busy=%0d required 2/1", fifo_count, busy);
    end
    rst = 1'b1;
    tick();
    got = {instr_ready, start, op_code, mat_size, scalar, busy, fifo_count,
           err_illegal, ovf_sticky, done_count};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL rstmid_values: got %h required %h", got, 37'h1_0000_0000 << 4);
    end
    rst = 1'b0; cu_ready = 1'b1;
    s = n_start;
    repeat (10) tick();
    n_cmp++;
    if (n_start != s || done_count !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_quiet: starts=%0d done=%0d busy=%0d required %0d/0/0", n_start, done_count, busy, s);
    end
  endtask

`ifdef DISPATCH_WDT_EN
  task automatic test_watchdog();
    apply_reset();
    instr_data = rand_word(1'b0); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();                       // ISSUE
    tick();                       // enter ACK, cu_ready stuck high
    repeat (WDT - 1) tick();
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_err++; $display("FAIL wdt_early: err_timeout=%0d required 0", err_timeout);
    end
    tick();
    n_cmp++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || done_count !== 16'd0) begin
      n_err++; $display("FAIL wdt_fire: err=%0d busy=%0d done=%0d required 1/0/0", err_timeout, busy, done_count);
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_err++; $display("FAIL wdt_clear: err_timeout=%0d required 0", err_timeout);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_illegal();
    test_overflow();
    test_random_traffic();
    test_reset_mid();
`ifdef DISPATCH_WDT_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
